// File: rtl/phys_map_cam.sv
// ============================================================================
// phys_map_cam -- physical-to-virtual rename map CAM with valid-vector
// checkpoints and registered, priority-encoded multi-port lookup.
// Optional: PHYS_MAP_CAM_BYPASS_EN (lookups see same-cycle next state).
// Revision: 1.0
// ============================================================================
`default_nettype none

module phys_map_cam #(
  parameter int CELLS           = 128,
  parameter int VIRT_COUNT      = 256,
  parameter int VIRT_ADDR_WIDTH = $clog2(VIRT_COUNT),
  parameter int PHYS_ADDR_WIDTH = $clog2(CELLS),
  parameter int WRITE_PORTS     = 4,
  parameter int INVAL_PORTS     = 4,
  parameter int READ_PORTS      = 4,
  parameter int CHECKPOINTS     = 8,
  parameter int CKPT_W          = $clog2(CHECKPOINTS)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clk_en,
  input  logic [WRITE_PORTS-1:0]                 wr_en,
  input  logic [WRITE_PORTS*PHYS_ADDR_WIDTH-1:0] wr_addr,
  input  logic [WRITE_PORTS*VIRT_ADDR_WIDTH-1:0] wr_tag,
  input  logic [INVAL_PORTS-1:0]                 inv_en,
  input  logic [INVAL_PORTS*PHYS_ADDR_WIDTH-1:0] inv_addr,
  input  logic [READ_PORTS-1:0]                  rd_en,
  input  logic [READ_PORTS*VIRT_ADDR_WIDTH-1:0]  rd_tag,
  output logic [READ_PORTS-1:0]                  rd_valid,
  output logic [READ_PORTS-1:0]                  rd_hit,
  output logic [READ_PORTS*PHYS_ADDR_WIDTH-1:0]  rd_addr,
  output logic [READ_PORTS-1:0]                  rd_multi,
  input  logic                                   ckpt_save,
  input  logic [CKPT_W-1:0]                      ckpt_save_id,
  input  logic                                   ckpt_restore,
  input  logic [CKPT_W-1:0]                      ckpt_restore_id
);

  logic [VIRT_ADDR_WIDTH-1:0]       r_tag  [CELLS];
  logic [CELLS-1:0]                 r_valid;
  logic [CELLS-1:0]                 r_snap [CHECKPOINTS];

  logic [READ_PORTS-1:0]                 r_rd_valid;
  logic [READ_PORTS-1:0]                 r_rd_hit;
  logic [READ_PORTS*PHYS_ADDR_WIDTH-1:0] r_rd_addr;
  logic [READ_PORTS-1:0]                 r_rd_multi;

  logic [VIRT_ADDR_WIDTH-1:0]       w_tag_nxt [CELLS];
  logic [CELLS-1:0]                 w_valid_nxt;
  logic [VIRT_ADDR_WIDTH-1:0]       w_src_tag [CELLS];
  logic [CELLS-1:0]                 w_src_valid;
  logic                             w_restore;
  logic                             w_save;

  logic [READ_PORTS-1:0]                 w_hit;
  logic [READ_PORTS*PHYS_ADDR_WIDTH-1:0] w_addr;
  logic [READ_PORTS-1:0]                 w_multi;

  assign w_restore = ckpt_restore && (int'(ckpt_restore_id) < CHECKPOINTS);
  assign w_save    = ckpt_save    && (int'(ckpt_save_id)    < CHECKPOINTS);

  // Invalidates first, then writes in ascending port order so the highest
  // port wins; a restore discards both and reloads only the valid vector.
  always_comb begin
    w_valid_nxt = r_valid;
    w_tag_nxt   = r_tag;
    for (int i = 0; i < INVAL_PORTS; i++) begin
      if (inv_en[i] && (int'(inv_addr[i*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH]) < CELLS))
        w_valid_nxt[inv_addr[i*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH]] = 1'b0;
    end
    for (int i = 0; i < WRITE_PORTS; i++) begin
      if (wr_en[i] && (int'(wr_addr[i*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH]) < CELLS)) begin
        w_valid_nxt[wr_addr[i*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH]] = 1'b1;
        w_tag_nxt[wr_addr[i*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH]]   =
          wr_tag[i*VIRT_ADDR_WIDTH +: VIRT_ADDR_WIDTH];
      end
    end
    if (w_restore) begin
      w_valid_nxt = r_snap[ckpt_restore_id];
      w_tag_nxt   = r_tag;
    end
  end

`ifdef PHYS_MAP_CAM_BYPASS_EN
  assign w_src_tag   = w_tag_nxt;
  assign w_src_valid = w_valid_nxt;
`else
  assign w_src_tag   = r_tag;
  assign w_src_valid = r_valid;
`endif

  // Ascending scan: the first match sets the address, any later one flags multi.
  always_comb begin
    w_hit   = '0;
    w_addr  = '0;
    w_multi = '0;
    for (int j = 0; j < READ_PORTS; j++) begin
      if (rd_en[j]) begin
        for (int c = 0; c < CELLS; c++) begin
          if (w_src_valid[c] &&
              (w_src_tag[c] == rd_tag[j*VIRT_ADDR_WIDTH +: VIRT_ADDR_WIDTH])) begin
            if (w_hit[j])
              w_multi[j] = 1'b1;
            else
              w_addr[j*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH] = PHYS_ADDR_WIDTH'(c);
            w_hit[j] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_rd_valid <= '0;
      r_rd_hit   <= '0;
      r_rd_addr  <= '0;
      r_rd_multi <= '0;
      for (int c = 0; c < CELLS; c++)
        r_tag[c] <= '0;
      for (int k = 0; k < CHECKPOINTS; k++)
        r_snap[k] <= '0;
    end else if (clk_en) begin
      r_valid    <= w_valid_nxt;
      r_tag      <= w_tag_nxt;
      if (w_save)
        r_snap[ckpt_save_id] <= w_valid_nxt;
      r_rd_valid <= rd_en;
      r_rd_hit   <= w_hit;
      r_rd_addr  <= w_addr;
      r_rd_multi <= w_multi;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_hit   = r_rd_hit;
  assign rd_addr  = r_rd_addr;
  assign rd_multi = r_rd_multi;

endmodule

`default_nettype wire

// File: tb/tb_phys_map_cam.sv
// ============================================================================
// tb_phys_map_cam -- table-driven bench for phys_map_cam with an expectation
// queue; honours PHYS_MAP_CAM_BYPASS_EN for same-cycle visibility cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_phys_map_cam;

  localparam int PA = 7;
  localparam int VA = 8;
  localparam int NP = 4;

  typedef struct packed {
    logic [NP-1:0]    wen;
    logic [NP*PA-1:0] waddr;
    logic [NP*VA-1:0] wtag;
    logic [NP-1:0]    ien;
    logic [NP*PA-1:0] iaddr;
    logic [NP-1:0]    ren;
    logic [NP*VA-1:0] rtag;
    logic             save;
    logic [2:0]       sid;
    logic             rest;
    logic [2:0]       rid;
    logic [NP-1:0]    ehit;
    logic [NP*PA-1:0] eaddr;
    logic [NP-1:0]    emulti;
  } vec_t;

  typedef struct packed {
    logic [NP-1:0]    valid;
    logic [NP-1:0]    hit;
    logic [NP*PA-1:0] addr;
    logic [NP-1:0]    multi;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk_en = 1'b1;
  logic [NP-1:0]    wr_en = '0;
  logic [NP*PA-1:0] wr_addr = '0;
  logic [NP*VA-1:0] wr_tag = '0;
  logic [NP-1:0]    inv_en = '0;
  logic [NP*PA-1:0] inv_addr = '0;
  logic [NP-1:0]    rd_en = '0;
  logic [NP*VA-1:0] rd_tag = '0;
  logic [NP-1:0]    rd_valid;
  logic [NP-1:0]    rd_hit;
  logic [NP*PA-1:0] rd_addr;
  logic [NP-1:0]    rd_multi;
  logic             ckpt_save = 1'b0;
  logic [2:0]       ckpt_save_id = '0;
  logic             ckpt_restore = 1'b0;
  logic [2:0]       ckpt_restore_id = '0;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t shown = '0;
  vec_t vecs[13];

  phys_map_cam dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_tag(wr_tag),
    .inv_en(inv_en), .inv_addr(inv_addr),
    .rd_en(rd_en), .rd_tag(rd_tag),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_addr(rd_addr), .rd_multi(rd_multi),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t blank();
    return '0;
  endfunction

  function automatic vec_t wr(vec_t v, int p, int a, int t);
    v.wen[p]           = 1'b1;
    v.waddr[p*PA +: PA] = PA'(a);
    v.wtag[p*VA +: VA]  = VA'(t);
    return v;
  endfunction

  function automatic vec_t inv(vec_t v, int p, int a);
    v.ien[p]            = 1'b1;
    v.iaddr[p*PA +: PA] = PA'(a);
    return v;
  endfunction

  function automatic vec_t rd(vec_t v, int p, int t, bit hit, int a, bit multi);
    v.ren[p]            = 1'b1;
    v.rtag[p*VA +: VA]  = VA'(t);
    v.ehit[p]           = hit;
    v.eaddr[p*PA +: PA] = hit ? PA'(a) : '0;
    v.emulti[p]         = multi;
    return v;
  endfunction

  function automatic vec_t ck(vec_t v, bit s, int sid, bit r, int rid);
    v.save = s;  v.sid = 3'(sid);
    v.rest = r;  v.rid = 3'(rid);
    return v;
  endfunction

  function automatic exp_t actual();
    return {rd_valid, rd_hit, rd_addr, rd_multi};
  endfunction

  task automatic chk(string name, exp_t a, exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got valid=%h hit=%h addr=%h multi=%h, want valid=%h hit=%h addr=%h multi=%h",
               name, a.valid, a.hit, a.addr, a.multi, e.valid, e.hit, e.addr, e.multi);
    end
  endtask

  task automatic pop_check(string name);
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(name, actual(), e);
      shown = e;
    end
  endtask

  // One cycle: compare what the previous lookup produced, then drive the next.
  task automatic apply(vec_t v, bit en, string name);
    @(negedge clk);
    pop_check(name);
    clk_en          = en;
    wr_en           = v.wen;   wr_addr  = v.waddr;  wr_tag = v.wtag;
    inv_en          = v.ien;   inv_addr = v.iaddr;
    rd_en           = v.ren;   rd_tag   = v.rtag;
    ckpt_save       = v.save;  ckpt_save_id    = v.sid;
    ckpt_restore    = v.rest;  ckpt_restore_id = v.rid;
    if (en) q.push_back({v.ren, v.ehit, v.eaddr, v.emulti});
    else    q.push_back(shown);
  endtask

  initial begin
    vecs[0]  = wr(blank(), 0, 5, 'h21);
    vecs[1]  = rd(rd(blank(), 0, 'h21, 1, 5, 0), 1, 'h99, 0, 0, 0);
    vecs[2]  = wr(wr(blank(), 0, 9, 'h10), 3, 9, 'h30);
    vecs[3]  = rd(rd(rd(blank(), 0, 'h30, 1, 9, 0), 1, 'h10, 0, 0, 0), 2, 'h21, 1, 5, 0);
    vecs[4]  = wr(wr(blank(), 1, 7, 'h44), 2, 2, 'h44);
    vecs[5]  = rd(wr(inv(blank(), 0, 2), 0, 2, 'h44), 0, 'h44, 1, 2, 1);
    vecs[6]  = rd(blank(), 0, 'h44, 1, 2, 1);
    vecs[7]  = ck(wr(wr(inv(inv(inv(inv(blank(), 0, 2), 1, 5), 2, 7), 3, 9),
                     0, 1, 'h51), 1, 3, 'h53), 1, 4, 0, 0);
    vecs[8]  = inv(wr(blank(), 0, 6, 'h66), 0, 1);
`ifdef PHYS_MAP_CAM_BYPASS_EN
    vecs[9]  = rd(ck(wr(wr(blank(), 0, 3, 'h99), 1, 8, 'h88), 0, 0, 1, 4), 0, 'h66, 0, 0, 0);
    vecs[11] = rd(wr(blank(), 2, 12, 'h07), 0, 'h07, 1, 12, 0);
`else
    vecs[9]  = rd(ck(wr(wr(blank(), 0, 3, 'h99), 1, 8, 'h88), 0, 0, 1, 4), 0, 'h66, 1, 6, 0);
    vecs[11] = rd(wr(blank(), 2, 12, 'h07), 0, 'h07, 0, 0, 0);
`endif
    vecs[10] = rd(rd(rd(rd(blank(), 0, 'h66, 0, 0, 0), 1, 'h51, 1, 1, 0),
                  2, 'h53, 1, 3, 0), 3, 'h99, 0, 0, 0);
    vecs[12] = rd(rd(blank(), 0, 'h07, 1, 12, 0), 1, 'h88, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("reset_state", actual(), '0);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Clock enable low: the write and lookup are discarded, outputs hold.
    apply(rd(wr(blank(), 0, 20, 'h20), 0, 'h07, 1, 12, 0), 1'b0, "vec12_result");
    apply(rd(rd(blank(), 0, 'h20, 0, 0, 0), 1, 'h07, 1, 12, 0), 1'b1, "clk_en_hold");
    apply(rd(blank(), 0, 'h07, 1, 12, 0), 1'b1, "clk_en_dropped");

    // Reset asserted while a lookup is in flight.
    #1 rst_n = 1'b0;
    #1 chk("async_reset_clear", actual(), '0);
    q.delete();
    shown = '0;
    @(negedge clk);
    chk("reset_held", actual(), '0);
    rst_n = 1'b1;
    apply(rd(blank(), 0, 'h07, 0, 0, 0), 1'b1, "none");
    apply(blank(), 1'b1, "post_reset_lookup");
    @(negedge clk);
    pop_check("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
